// File: rtl/vga_pkg.sv
// Default 800x600@60 raster constants, counter/colour widths and the colour-bar table.
// Latency: none (constants only). Backpressure: none.
package vga_pkg;
    localparam int COUNT_W = 11;
    localparam int RGB_W   = 12;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int BAR_COUNT = 8;
    localparam int BAR_IDX_W = 3;
    localparam logic [RGB_W-1:0] BAR_COLOURS [BAR_COUNT] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };
endpackage

// File: rtl/vga_if.sv
// Raster bus carried from the timing generator through the drawing stages.
// Latency: none (wires). Backpressure: none; every stage consumes one pixel per clock.
interface vga_if;
    import vga_pkg::*;

    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus blank/sync flags decoded from the next count.
// Latency: count and flags register on the same edge; wrap is combinational. Backpressure: inc low holds.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL  = DEF_H_TOTAL,
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter logic POL    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic               wrap,
    output logic [COUNT_W-1:0] count,
    output logic               blnk,
    output logic               sync
);
    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);

    logic [COUNT_W-1:0] count_nxt;

    always_comb begin
        wrap      = inc && (count == LAST);
        count_nxt = count;
        if (wrap) begin
            count_nxt = '0;
        end else if (inc) begin
            count_nxt = count + COUNT_W'(1);
        end
    end

    // Flags decode count_nxt so they land on the same edge as the count they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= ~POL;
        end else begin
            count <= count_nxt;
            blnk  <= int'(count_nxt) >= ACTIVE;
            sync  <= (int'(count_nxt) >= ACTIVE + FP && int'(count_nxt) < ACTIVE + FP + SYNC) ? POL : ~POL;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Head of the VGA pipeline: raster counters, sync/blank, frame_start and (VGA_TEST_PATTERN_EN) colour bars.
// Latency: all outputs registered, flags aligned with hcount/vcount. Backpressure: en low freezes everything.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic frame_start,
    vga_if.out   out
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << COUNT_W) || V_TOTAL > (1 << COUNT_W)) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    logic               started;
    logic               h_inc, h_wrap, v_inc, v_wrap;
    logic [COUNT_W-1:0] h_count, v_count, h_nxt, v_nxt;
    logic               h_blnk, h_sync, v_blnk, v_sync;
    logic [RGB_W-1:0]   rgb_q, rgb_nxt;

    // The first enabled edge after reset only presents (0,0); counting begins on the next one.
    assign h_inc = en & started;
    assign v_inc = h_inc & h_wrap;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .POL(HS_POL)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .inc(h_inc), .wrap(h_wrap),
        .count(h_count), .blnk(h_blnk), .sync(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .POL(VS_POL)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .inc(v_inc), .wrap(v_wrap),
        .count(v_count), .blnk(v_blnk), .sync(v_sync)
    );

    always_comb begin
        h_nxt = h_count;
        v_nxt = v_count;
        if (h_wrap) begin
            h_nxt = '0;
        end else if (h_inc) begin
            h_nxt = h_count + COUNT_W'(1);
        end
        if (v_wrap) begin
            v_nxt = '0;
        end else if (v_inc) begin
            v_nxt = v_count + COUNT_W'(1);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [BAR_IDX_W-1:0] bar_idx;
    assign bar_idx = BAR_IDX_W'(int'(h_nxt) / (H_ACTIVE / BAR_COUNT));

    always_comb begin
        rgb_nxt = '0;
        if (int'(h_nxt) < H_ACTIVE && int'(v_nxt) < V_ACTIVE) begin
            rgb_nxt = BAR_COLOURS[bar_idx];
        end
    end
`else
    assign rgb_nxt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            frame_start <= 1'b0;
            rgb_q       <= '0;
        end else if (en) begin
            started     <= 1'b1;
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            rgb_q       <= rgb_nxt;
        end
    end

    assign out.hcount = h_count;
    assign out.vcount = v_count;
    assign out.hsync  = h_sync;
    assign out.vsync  = v_sync;
    assign out.hblnk  = h_blnk;
    assign out.vblnk  = v_blnk;
    assign out.rgb    = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a per-cycle scoreboard against a raster reference model.
// Uses the default horizontal timing and a shortened vertical timing so whole frames stay short.
module tb_vga_timing_gen;
    localparam int HA = 800, HF = 40, HS = 128, HB = 88;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [11:0] EXP_RGB_0   = 12'hFFF;
    localparam logic [11:0] EXP_RGB_150 = 12'hFF0;
`else
    localparam logic [11:0] EXP_RGB_0   = 12'h000;
    localparam logic [11:0] EXP_RGB_150 = 12'h000;
`endif

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic frame_start;

    vga_if vif ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start), .out(vif)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    obs_t exp_q[$];

    int   mh = 0, mv = 0;
    bit   mstart = 1'b0;
    logic mfs = 1'b0;

    function automatic logic [11:0] bar_rgb(input int idx);
        case (idx)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Before the first enabled edge the outputs sit at reset values, which are all zero for POL=1.
    function automatic obs_t model_obs();
        obs_t o;
        o = '0;
        if (mstart) begin
            o.h   = 11'(mh);
            o.v   = 11'(mv);
            o.hb  = (mh >= HA);
            o.vb  = (mv >= VA);
            o.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
            o.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
            o.fs  = mfs;
            o.rgb = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
            if (!o.hb && !o.vb) o.rgb = bar_rgb(mh / (HA / 8));
`endif
        end
        return o;
    endfunction

    function automatic void model_step(input logic e);
        if (e) begin
            if (!mstart) begin
                mstart = 1'b1;
                mh = 0;
                mv = 0;
            end else if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mfs = (mh == 0) && (mv == 0);
        end
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.h   = vif.hcount;
        o.v   = vif.vcount;
        o.hs  = vif.hsync;
        o.vs  = vif.vsync;
        o.hb  = vif.hblnk;
        o.vb  = vif.vblnk;
        o.rgb = vif.rgb;
        o.fs  = frame_start;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e);
        obs_t got, exp;
        en = e;
        model_step(e);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        cyc++;
        got = sample();
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h expected none", got);
        end else begin
            exp = exp_q.pop_front();
            chk("scoreboard", 64'(got), 64'(exp));
        end
    endtask

    initial begin
        int n, t_fs, period, fs_cnt, bad_edge;
        int hb_first, hs_first, hs_last, hs_cnt, wrap_h, wrap_v;
        int vs_min, vs_max, vb_min, vb_max;
        logic [10:0] prev_h;
        logic prev_vs, prev_vb;
        bit wrapped;
        obs_t snap;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_hcount", 64'(vif.hcount), 0);
        chk("rst_vcount", 64'(vif.vcount), 0);
        chk("rst_hsync", 64'(vif.hsync), 0);
        chk("rst_vsync", 64'(vif.vsync), 0);
        chk("rst_blnk", 64'({vif.hblnk, vif.vblnk}), 0);
        chk("rst_rgb", 64'(vif.rgb), 0);
        chk("rst_fs", 64'(frame_start), 0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);

        // First enabled edge presents (0,0) with frame_start
        step(1'b1);
        chk("first_fs", 64'(frame_start), 1);
        chk("first_pos", 64'({vif.hcount, vif.vcount}), 0);
        chk("first_rgb", 64'(vif.rgb), 64'(EXP_RGB_0));

        // One full line
        hb_first = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
        wrap_h = -1; wrap_v = -1; wrapped = 1'b0; n = 0;
        while (!wrapped && n < HT + 5) begin
            prev_h = vif.hcount;
            step(1'b1);
            n++;
            if (vif.hblnk && hb_first < 0) hb_first = int'(vif.hcount);
            if (vif.hsync) begin
                if (hs_first < 0) hs_first = int'(vif.hcount);
                hs_last = int'(vif.hcount);
                hs_cnt++;
            end
            if (prev_h == 11'(HT - 1)) begin
                wrapped = 1'b1;
                wrap_h = int'(vif.hcount);
                wrap_v = int'(vif.vcount);
            end
        end
        chk("hblnk_rise", 64'(hb_first), 800);
        chk("hsync_first", 64'(hs_first), 840);
        chk("hsync_last", 64'(hs_last), 967);
        chk("hsync_width", 64'(hs_cnt), 128);
        chk("wrap_hcount", 64'(wrap_h), 0);
        chk("wrap_vcount", 64'(wrap_v), 1);

        // Align to the next frame start
        n = 0;
        while (frame_start !== 1'b1 && n < FRAME + 10) begin
            step(1'b1);
            n++;
        end
        chk("sync_fs", 64'(frame_start), 1);

        // One undisturbed frame
        period = 0; fs_cnt = 0; bad_edge = 0;
        vs_min = VT; vs_max = -1; vb_min = VT; vb_max = -1;
        prev_vs = vif.vsync; prev_vb = vif.vblnk;
        do begin
            step(1'b1);
            period++;
            if (frame_start) fs_cnt++;
            if (vif.vsync) begin
                if (int'(vif.vcount) < vs_min) vs_min = int'(vif.vcount);
                if (int'(vif.vcount) > vs_max) vs_max = int'(vif.vcount);
            end
            if (vif.vblnk) begin
                if (int'(vif.vcount) < vb_min) vb_min = int'(vif.vcount);
                if (int'(vif.vcount) > vb_max) vb_max = int'(vif.vcount);
            end
            if ((vif.vsync !== prev_vs || vif.vblnk !== prev_vb) && vif.hcount != 0) bad_edge++;
            prev_vs = vif.vsync;
            prev_vb = vif.vblnk;
        end while (!frame_start && period < FRAME + 10);
        t_fs = cyc;
        chk("frame_period", 64'(period), 64'(FRAME));
        chk("fs_per_frame", 64'(fs_cnt), 1);
        chk("vsync_min", 64'(vs_min), 64'(VA + VF));
        chk("vsync_max", 64'(vs_max), 64'(VA + VF + VS - 1));
        chk("vblnk_min", 64'(vb_min), 64'(VA));
        chk("vblnk_max", 64'(vb_max), 64'(VT - 1));
        chk("v_edge_off_h0", 64'(bad_edge), 0);

        // frame_start stays high while en is low at (0,0)
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("fs_hold", 64'(frame_start), 1);
        end
        step(1'b1);
        chk("fs_drop", 64'(frame_start), 0);

        // Colour bars on line 0
        n = 0;
        while (vif.hcount != 150 && n < HT) begin step(1'b1); n++; end
        chk("rgb_h150", 64'(vif.rgb), 64'(EXP_RGB_150));
        n = 0;
        while (vif.hcount != 799 && n < HT) begin step(1'b1); n++; end
        chk("rgb_h799", 64'(vif.rgb), 0);
        step(1'b1);
        chk("rgb_hblnk", 64'({vif.hblnk, vif.rgb}), 64'({1'b1, 12'h000}));

        // en low for 5 cycles at hcount=500
        n = 0;
        while (!(vif.vcount == 1 && vif.hcount == 500) && n < 2 * HT) begin step(1'b1); n++; end
        chk("reach_h500", 64'(vif.hcount), 500);
        snap = sample();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk("en_low_hold", 64'(sample()), 64'(snap));
        end
        step(1'b1);
        chk("resume_h", 64'(vif.hcount), 501);
        n = 0;
        while (frame_start !== 1'b1 && n < FRAME + 20) begin step(1'b1); n++; end
        chk("stretched_period", 64'(cyc - t_fs), 64'(FRAME + 8));

        // Asynchronous reset between clock edges
        n = 0;
        while (!(vif.vcount == 2 && vif.hcount == 300) && n < FRAME) begin step(1'b1); n++; end
        chk("reach_v2h300", 64'({vif.vcount, vif.hcount}), 64'({11'd2, 11'd300}));
        rst_n = 1'b0;
        #2;
        chk("async_rst", 64'(sample()), 0);
        mstart = 1'b0; mh = 0; mv = 0; mfs = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        step(1'b1);
        chk("rerun_fs", 64'(frame_start), 1);
        step(1'b1);
        chk("rerun_h1", 64'({vif.hcount, frame_start}), 64'({11'd1, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
